// File: rtl/calc_kp_pkg.sv
// Shared keypad geometry, FSM state type and key-code field helpers
// for the keypad emulator.
package calc_kp_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } kp_state_t;

  function automatic logic [1:0] key_row(input logic [KEY_W-1:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [KEY_W-1:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO with registered pointers; the head entry is
// visible on dout combinationally. Pushes into a full FIFO are ignored.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // A full FIFO rejects the push even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/keypad_emulator.sv
// Replays queued key codes onto a 4x4 keypad matrix: each key is held for
// HOLD_CYCLES, then released for GAP_CYCLES, answering the column scan.
module keypad_emulator
  import calc_kp_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 500000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                KeyValid,
  input  logic [KEY_W-1:0]    KeyCode,
  output logic                KeyReady,
  input  logic [NUM_COLS-1:0] cols,
  output logic [NUM_ROWS-1:0] rows,
  output logic                Pressing,
  output logic                Busy,
  output logic                DropErr
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  kp_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0]    code_q, code_d;
  logic [NUM_ROWS-1:0] rows_q, rows_d;
  logic                press_q;
  logic                drop_q, drop_d;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [KEY_W-1:0]    fifo_dout;

  key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Clear (Clear),
    .push  (KeyValid),
    .din   (KeyCode),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          code_d   = fifo_dout;
          cnt_d    = HOLD_LOAD;
          state_d  = PRESS;
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the selected column is looked at, so odd scan patterns are harmless.
  always_comb begin
    rows_d = '1;
    if (state_q == PRESS && !cols[key_col(code_q)]) rows_d[key_row(code_q)] = 1'b0;
    drop_d = drop_q | (KeyValid & fifo_full);
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      rows_q  <= '1;
      press_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      rows_q  <= rows_d;
      press_q <= (state_d == PRESS);
      drop_q  <= drop_d;
    end
  end

  assign rows     = rows_q;
  assign Pressing = press_q;
  assign Busy     = (state_q != IDLE) || !fifo_empty;
  assign DropErr  = drop_q;
  assign KeyReady = !fifo_full;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a timeline model of accepted keys predicts
// every output per cycle; a queue of expected press starts is checked.
module tb_keypad_emulator;

  localparam int HOLD   = 4;
  localparam int GAP    = 3;
  localparam int DEPTH  = 4;
  localparam int PERIOD = HOLD + GAP + 1;

  logic       Clock = 1'b0;
  logic       Clear = 1'b1;
  logic       KeyValid = 1'b0;
  logic [3:0] KeyCode = 4'h0;
  logic [3:0] cols = 4'hF;
  logic       KeyReady;
  logic [3:0] rows;
  logic       Pressing, Busy, DropErr;

  keypad_emulator #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .KeyValid (KeyValid),
    .KeyCode  (KeyCode),
    .KeyReady (KeyReady),
    .cols     (cols),
    .rows     (rows),
    .Pressing (Pressing),
    .Busy     (Busy),
    .DropErr  (DropErr)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int         acc;
    int         start;
    logic [3:0] code;
  } key_t;

  key_t       klist[$];
  key_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         n = 0;
  int         last_start = -1000;
  logic       m_drop = 1'b0;
  logic [3:0] exp_rows = 4'hF;
  logic       mon_en = 1'b0;
  logic       prev_press = 1'b0;
  int         col_mode = 0;
  int         col_ph = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at sample %0d", name, act, exp, n);
    end
  endtask

  // Key being held at sample t, if any: presses occupy [start, start+HOLD-1].
  function automatic bit m_press(input int t, output logic [3:0] code);
    code = 4'h0;
    foreach (klist[i])
      if (t >= klist[i].start && t <= klist[i].start + HOLD - 1) begin
        code = klist[i].code;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit m_busy(input int t);
    foreach (klist[i])
      if (t >= klist[i].acc + 1 && t <= klist[i].start + HOLD + GAP - 1) return 1'b1;
    return 1'b0;
  endfunction

  // Keys sitting in the FIFO: accepted but not yet popped (pop precedes start).
  function automatic int m_count(input int t);
    int c = 0;
    foreach (klist[i])
      if (t >= klist[i].acc + 1 && t <= klist[i].start - 1) c++;
    return c;
  endfunction

  always @(negedge Clock) begin : monitor
    logic [3:0] pc;
    bit         pr;
    int         cnt;
    int         st;
    key_t       e;
    key_t       k;
    if (!mon_en) begin
      klist.delete();
      exp_q.delete();
      last_start = -1000;
      m_drop     = 1'b0;
      exp_rows   = 4'hF;
      prev_press = 1'b0;
    end else begin
      pr  = m_press(n, pc);
      cnt = m_count(n);
      check("rows", 32'(rows), 32'(exp_rows));
      check("Pressing", 32'(Pressing), 32'(pr));
      check("Busy", 32'(Busy), 32'(m_busy(n)));
      check("KeyReady", 32'(KeyReady), 32'(cnt < DEPTH));
      check("DropErr", 32'(DropErr), 32'(m_drop));
      if (Pressing === 1'b1 && !prev_press) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL press_start: got unexpected press at sample %0d expected none", n);
        end else begin
          e = exp_q.pop_front();
          check("press_start", 32'(n), 32'(e.start));
        end
      end
      prev_press = (Pressing === 1'b1);

      if (Clear) begin
        klist.delete();
        exp_q.delete();
        last_start = -1000;
        m_drop     = 1'b0;
        exp_rows   = 4'hF;
      end else begin
        exp_rows = 4'hF;
        if (pr && !cols[pc[1:0]]) exp_rows[pc[3:2]] = 1'b0;
        if (KeyValid) begin
          if (cnt < DEPTH) begin
            st = (n + 2 > last_start + PERIOD) ? n + 2 : last_start + PERIOD;
            k.acc   = n;
            k.start = st;
            k.code  = KeyCode;
            klist.push_back(k);
            exp_q.push_back(k);
            last_start = st;
          end else begin
            m_drop = 1'b1;
          end
        end
        while (klist.size() > 0 && klist[0].start + PERIOD < n) void'(klist.pop_front());
      end
    end
    n++;
  end

  task automatic step(input logic v, input logic [3:0] c, input logic clr);
    @(posedge Clock);
    #2;
    KeyValid = v;
    KeyCode  = c;
    Clear    = clr;
    case (col_mode)
      0: begin
        cols   = ~(4'b0001 << col_ph);
        col_ph = (col_ph + 1) % 4;
      end
      1:       cols = 4'($urandom);
      2:       cols = 4'hF;
      default: cols = 4'h0;
    endcase
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 4'($urandom), 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge Clock);
    #2;
    Clear  = 1'b0;
    mon_en = 1'b1;

    // single key, one-low column scan
    col_mode = 0;
    step(1'b1, 4'b0110, 1'b0);
    idle(14);

    // four keys back-to-back
    col_mode = 1;
    step(1'b1, 4'd0, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd10, 1'b0);
    step(1'b1, 4'd15, 1'b0);
    idle(40);

    // overflow: keep pushing until the FIFO rejects
    col_mode = 0;
    for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom), 1'b0);
    idle(60);

    // column independence
    col_mode = 2;
    step(1'b1, 4'h3, 1'b0);
    idle(12);
    col_mode = 3;
    step(1'b1, 4'h3, 1'b0);
    idle(12);

    // Clear in the second cycle of a press with two keys still queued
    col_mode = 0;
    step(1'b1, 4'($urandom), 1'b0);
    step(1'b1, 4'($urandom), 1'b0);
    step(1'b1, 4'($urandom), 1'b0);
    step(1'b0, 4'h0, 1'b1);
    idle(20);

    // randomized traffic with occasional Clear
    for (int i = 0; i < 400; i++) begin
      col_mode = int'($urandom_range(0, 3));
      step($urandom_range(0, 2) == 0, 4'($urandom), $urandom_range(0, 99) == 0);
    end
    idle(60);

    check("pending_presses", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
